// File: rtl/result_fifo_bank.sv
// rtl/result_fifo_bank.sv - multi-channel result FIFO bank drained through a registered Avalon-MM read port
// Each channel owns a circular RAM plus a prefetched head register, so one bus read pops one word per cycle.
module result_fifo_bank #(
  parameter int          NCH        = 3,
  parameter int          WIDTH      = 32,
  parameter int          DEPTH      = 4096,
  parameter int          THRESH     = DEPTH / 2,
  parameter logic [31:0] EMPTY_WORD = 32'hFFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic                 chipselect,
  input  logic                 read,
  input  logic                 write,
  input  logic [4:0]           address,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic                 irq
);

  localparam int             PW       = $clog2(DEPTH);
  localparam int             CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]  THR_CNT  = CW'(THRESH);

  logic [WIDTH-1:0] mem [NCH][DEPTH];
  logic [WIDTH-1:0] head_q [NCH];
  logic [WIDTH-1:0] head_d [NCH];
  logic [PW-1:0]    wr_ptr_q [NCH];
  logic [PW-1:0]    wr_ptr_d [NCH];
  logic [PW-1:0]    rd_ptr_q [NCH];
  logic [PW-1:0]    rd_ptr_d [NCH];
  logic [CW-1:0]    count_q [NCH];
  logic [CW-1:0]    count_d [NCH];
  logic [NCH-1:0]   ovf_q, ovf_d, udf_q, udf_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic [NCH-1:0]   sel, empty_c, full_c, push_acc, pop, flush;
  logic             rd_en, wr_en;
  logic [1:0]       region;
  logic [2:0]       ch;
  logic [7:0]       nonempty;
  logic             unused_wdata;

  assign unused_wdata = ^{writedata[31:4], writedata[1:0]};

  always_comb begin
    rd_en      = chipselect & read;
    wr_en      = chipselect & write & ~read;
    region     = address[4:3];
    ch         = address[2:0];
    readdata_d = rd_en ? 32'h0 : readdata_q;
    irq_d      = 1'b0;
    nonempty   = '0;
    for (int c = 0; c < NCH; c++) begin
      sel[c]      = (int'(ch) == c);
      empty_c[c]  = (count_q[c] == '0);
      full_c[c]   = (count_q[c] == FULL_CNT);
      pop[c]      = rd_en & (region == 2'd0) & sel[c] & ~empty_c[c];
      flush[c]    = wr_en & (region == 2'd1) & sel[c];
      // A full channel still takes a push when the same cycle pops it.
      push_acc[c] = in_valid[c] & ~flush[c] & (~full_c[c] | pop[c]);
      wr_ptr_d[c] = flush[c] ? '0 : wr_ptr_q[c] + PW'(push_acc[c]);
      rd_ptr_d[c] = flush[c] ? '0 : rd_ptr_q[c] + PW'(pop[c]);
      count_d[c]  = flush[c] ? '0 : count_q[c] + CW'(push_acc[c]) - CW'(pop[c]);
      ovf_d[c]    = (in_valid[c] & ~flush[c] & full_c[c] & ~pop[c]) |
                    (ovf_q[c] & ~(wr_en & (region == 2'd2) & sel[c] & writedata[2]));
      udf_d[c]    = (rd_en & (region == 2'd0) & sel[c] & empty_c[c]) |
                    (udf_q[c] & ~(wr_en & (region == 2'd2) & sel[c] & writedata[3]));
      // Forward the incoming word when it lands in the slot that becomes the head.
      head_d[c]   = (push_acc[c] && (wr_ptr_q[c] == rd_ptr_d[c])) ?
                    in_data[c*WIDTH +: WIDTH] : mem[c][rd_ptr_d[c]];
      nonempty[c] = ~empty_c[c];
      if (count_q[c] >= THR_CNT) irq_d = 1'b1;
      if (rd_en && sel[c]) begin
        case (region)
          2'd0:    readdata_d = empty_c[c] ? EMPTY_WORD : 32'(head_q[c]);
          2'd1:    readdata_d = 32'(count_q[c]);
          2'd2:    readdata_d = {28'h0, udf_q[c], ovf_q[c], full_c[c], empty_c[c]};
          default: readdata_d = 32'h0;
        endcase
      end
    end
    if (rd_en && (region == 2'd3) && (ch == 3'd0)) readdata_d = {23'h0, irq_q, nonempty};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        count_q[c]  <= '0;
      end
      ovf_q      <= '0;
      udf_q      <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  // RAM and head register carry no reset; their contents are only exposed while count is nonzero.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (push_acc[c]) mem[c][wr_ptr_q[c]] <= in_data[c*WIDTH +: WIDTH];
      head_q[c] <= head_d[c];
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
